// File: rtl/reg_fanout_pkg.sv
// Shared defaults and sizing helpers for the register fanout pipeline.
package reg_fanout_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_DEPTH    = 5;
  localparam int unsigned DEF_CHANNELS = 6;

  // Occupancy counts 0..DEPTH+1 (source register plus DEPTH stages).
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/reg_fanout_pipe_stage.sv
// One valid+data pipeline register with load/hold/clear control; load wins over clear.
module pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_fanout_pipe.sv
// Source register + DEPTH stallable stages, head word broadcast to CHANNELS masked sinks.
module reg_fanout_pipe
  import reg_fanout_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [CHANNELS-1:0]            chan_en,
  output logic [CHANNELS-1:0]            out_valid,
  input  logic [CHANNELS-1:0]            out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [occ_width(DEPTH)-1:0]    occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH:0]     vld;
  logic [DEPTH:0]     adv;
  logic [DEPTH:0]     load;
  logic [DEPTH:0]     clear;
  logic [WIDTH-1:0]   dat [DEPTH+1];

  logic [CHANNELS-1:0] em;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] take;
  logic                head_vld;
  logic                retire;
  logic                accept;

  assign head_vld  = vld[DEPTH];
  assign out_valid = {CHANNELS{head_vld}} & em & ~done;
  assign take      = out_valid & out_ready;
  assign retire    = head_vld && ((em & ~(done | take)) == '0);
  assign out_data  = dat[DEPTH];

  // Advance is resolved from the head backwards so a retiring head lets the whole pipe shift.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = retire;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = vld[DEPTH-1-k] && (!vld[DEPTH-k] || adv[DEPTH-k]);
    end
  end

  assign in_ready = !rst && (!vld[0] || adv[0]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load     = '0;
    clear    = '0;
    load[0]  = accept;
    clear[0] = adv[0];
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      load[k]  = adv[k-1];
      clear[k] = adv[k];
    end
  end

  for (genvar g = 0; g <= DEPTH; g++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .clear (clear[g]),
      .d     ((g == 0) ? in_data : dat[(g == 0) ? 0 : g-1]),
      .valid (vld[g]),
      .q     (dat[g])
    );
  end

  // em is captured only as a word enters the head, so mid-word chan_en changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      em   <= '0;
      done <= '0;
    end else begin
      if (load[DEPTH]) em <= chan_en;
      if (retire) done <= '0;
      else        done <= done | take;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else if (accept && !retire) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!accept && retire) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule
